// File: rtl/me_pkg.sv
// Shared types and default geometry for the motion-estimation frame scheduler.
package me_pkg;

    localparam int unsigned FRAME_W_DEF = 32;
    localparam int unsigned FRAME_H_DEF = 32;
    localparam int unsigned ADDR_W_DEF  = 11;
    localparam int unsigned MV_W_DEF    = 4;
    localparam int unsigned WIN_DEF     = 19;

    // Block grid for the default frame geometry.
    localparam int unsigned NBX_DEF   = FRAME_W_DEF / 4;
    localparam int unsigned NBY_DEF   = FRAME_H_DEF / 4;
    localparam int unsigned NB_DEF    = NBX_DEF * NBY_DEF;
    localparam int unsigned BLK_W_DEF = $clog2(NB_DEF);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } sched_state_e;

endpackage

// File: rtl/me_win_addr_gen.sv
// Block (bx,by) -> current-block base address and clamped search-window base address.
module me_win_addr_gen
    import me_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned FRAME_H = FRAME_H_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned WIN     = WIN_DEF,
    parameter int unsigned BX_W    = 3,
    parameter int unsigned BY_W    = 3
) (
    input  logic [BX_W-1:0]   bx,
    input  logic [BY_W-1:0]   by,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] win_addr
);

    // Two guard bits so the -8 offset and the clamp bounds stay exact before truncation.
    localparam int unsigned CW = ADDR_W + 2;

    localparam logic signed [CW-1:0] HALF_OFS = CW'(8);
    localparam logic signed [CW-1:0] X_MAX    = CW'(FRAME_W - WIN);
    localparam logic signed [CW-1:0] Y_MAX    = CW'(FRAME_H - WIN);

    logic signed [CW-1:0] wx_raw;
    logic signed [CW-1:0] wy_raw;
    logic signed [CW-1:0] wx_c;
    logic signed [CW-1:0] wy_c;

    // Centre the window on the block, then pull it back inside the frame.
    always_comb begin
        wx_raw = $signed(CW'({bx, 2'b00})) - HALF_OFS;
        wy_raw = $signed(CW'({by, 2'b00})) - HALF_OFS;

        wx_c = wx_raw;
        if (wx_raw[CW-1]) begin
            wx_c = '0;
        end else if (wx_raw > X_MAX) begin
            wx_c = X_MAX;
        end

        wy_c = wy_raw;
        if (wy_raw[CW-1]) begin
            wy_c = '0;
        end else if (wy_raw > Y_MAX) begin
            wy_c = Y_MAX;
        end

        cur_addr = ADDR_W'({by, 2'b00}) * ADDR_W'(FRAME_W) + ADDR_W'({bx, 2'b00});
        win_addr = ADDR_W'(wy_c) * ADDR_W'(FRAME_W) + ADDR_W'(wx_c);
    end

endmodule

// File: rtl/me_frame_sched.sv
// Frame-level ME scheduler: walks 4x4 blocks in raster order, launches the ME core per
// block and forwards each resulting motion vector to the MV store over valid/ready.
// Optional watchdog on the ME wait: define ME_SCHED_TIMEOUT_EN.
module me_frame_sched
    import me_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned FRAME_H = FRAME_H_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MV_W    = MV_W_DEF,
    parameter int unsigned WIN     = WIN_DEF
`ifdef ME_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TMO     = 255
`endif
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         frame_done,
    output logic                                         me_start,
    output logic [ADDR_W-1:0]                            me_cur_addr,
    output logic [ADDR_W-1:0]                            me_win_addr,
    input  logic                                         me_done,
    input  logic [MV_W-1:0]                              me_mvx,
    input  logic [MV_W-1:0]                              me_mvy,
    output logic                                         mv_valid,
    input  logic                                         mv_ready,
    output logic [$clog2((FRAME_W/4)*(FRAME_H/4))-1:0]   mv_blk_idx,
    output logic [MV_W-1:0]                              mv_x,
    output logic [MV_W-1:0]                              mv_y,
    output logic                                         mv_err
);

    localparam int unsigned NBX   = FRAME_W / 4;
    localparam int unsigned NBY   = FRAME_H / 4;
    localparam int unsigned NB    = NBX * NBY;
    localparam int unsigned BX_W  = $clog2(NBX);
    localparam int unsigned BY_W  = $clog2(NBY);
    localparam int unsigned IDX_W = $clog2(NB);

    sched_state_e     state_q;
    sched_state_e     state_nxt;
    logic [BX_W-1:0]  bx_q;
    logic [BX_W-1:0]  bx_nxt;
    logic [BY_W-1:0]  by_q;
    logic [BY_W-1:0]  by_nxt;
    logic [IDX_W-1:0] blk_q;
    logic [IDX_W-1:0] blk_nxt;
    logic             cap_c;
    logic             hs_c;
    logic [ADDR_W-1:0] gen_cur;
    logic [ADDR_W-1:0] gen_win;

`ifdef ME_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit_c;
`endif

    assign hs_c = mv_valid & mv_ready;

    // Addresses are computed for the block about to be issued and latched on ISSUE entry.
    me_win_addr_gen #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .ADDR_W  (ADDR_W),
        .WIN     (WIN),
        .BX_W    (BX_W),
        .BY_W    (BY_W)
    ) u_addr_gen (
        .bx       (bx_nxt),
        .by       (by_nxt),
        .cur_addr (gen_cur),
        .win_addr (gen_win)
    );

    // FSM state and block position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_nxt;
            bx_q    <= bx_nxt;
            by_q    <= by_nxt;
            blk_q   <= blk_nxt;
        end
    end

    // Next-state, block advance and capture decisions.
    always_comb begin
        state_nxt = state_q;
        bx_nxt    = bx_q;
        by_nxt    = by_q;
        blk_nxt   = blk_q;
        cap_c     = 1'b0;
`ifdef ME_SCHED_TIMEOUT_EN
        tmo_hit_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    bx_nxt    = '0;
                    by_nxt    = '0;
                    blk_nxt   = '0;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (me_done) begin
                    state_nxt = EMIT;
                    cap_c     = 1'b1;
`ifdef ME_SCHED_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TMO - 1)) begin
                    state_nxt = EMIT;
                    tmo_hit_c = 1'b1;
`endif
                end
            end
            EMIT: begin
                if (hs_c) begin
                    if (blk_q == IDX_W'(NB - 1)) begin
                        state_nxt = DONE;
                        bx_nxt    = '0;
                        by_nxt    = '0;
                        blk_nxt   = '0;
                    end else begin
                        state_nxt = ISSUE;
                        blk_nxt   = blk_q + IDX_W'(1);
                        if (bx_q == BX_W'(NBX - 1)) begin
                            bx_nxt = '0;
                            by_nxt = by_q + BY_W'(1);
                        end else begin
                            bx_nxt = bx_q + BX_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            me_start    <= 1'b0;
            mv_valid    <= 1'b0;
            me_cur_addr <= '0;
            me_win_addr <= '0;
            mv_blk_idx  <= '0;
            mv_x        <= '0;
            mv_y        <= '0;
        end else begin
            busy       <= (state_nxt == ISSUE) || (state_nxt == WAIT) || (state_nxt == EMIT);
            frame_done <= (state_nxt == DONE);
            me_start   <= (state_nxt == ISSUE);
            mv_valid   <= (state_nxt == EMIT);
            if (state_nxt == ISSUE) begin
                me_cur_addr <= gen_cur;
                me_win_addr <= gen_win;
                mv_blk_idx  <= blk_nxt;
            end
            if (cap_c) begin
                mv_x <= me_mvx;
                mv_y <= me_mvy;
`ifdef ME_SCHED_TIMEOUT_EN
            end else if (tmo_hit_c) begin
                mv_x <= '0;
                mv_y <= '0;
`endif
            end
        end
    end

`ifdef ME_SCHED_TIMEOUT_EN
    // Watchdog: counts cycles spent in WAIT, cleared on each WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != WAIT) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    // Error flag travels with the record; set only by a watchdog abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_err <= 1'b0;
        end else if (cap_c) begin
            mv_err <= 1'b0;
        end else if (tmo_hit_c) begin
            mv_err <= 1'b1;
        end
    end
`else
    assign mv_err = 1'b0;
`endif

endmodule
